// File: rtl/fft_frame_feeder.sv
// rtl/fft_frame_feeder.sv - real sample stream to fixed-length complex AXI-Stream frames
//
// Ports:
//   clk_in, rst_in         clock, asynchronous active-low reset
//   sample_in/_valid_in    real input samples; sample_ready_out is the handshake ready
//   flush_in               pulse: zero-pad the current partial frame to FFT_POINTS words
//   m_axis_*               frame output, {imag=0, real=sample}, tlast on the final word
//   frame_count_out        frames completed on the output (tlast handshakes), wraps
//   fifo_level_out         output FIFO occupancy
//   overflow_out           sticky: a sample was discarded because the FIFO was full
module fft_frame_feeder #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int FFT_POINTS   = 1024,
    parameter int FIFO_DEPTH   = 16,
    parameter int ALLOW_DROP   = 0
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic [SAMPLE_WIDTH-1:0]         sample_in,
    input  logic                            sample_valid_in,
    output logic                            sample_ready_out,
    input  logic                            flush_in,
    output logic [2*SAMPLE_WIDTH-1:0]       m_axis_tdata,
    output logic                            m_axis_tvalid,
    output logic                            m_axis_tlast,
    input  logic                            m_axis_tready,
    output logic [15:0]                     frame_count_out,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level_out,
    output logic                            overflow_out
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = $clog2(FFT_POINTS);
    localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(FIFO_DEPTH);
    localparam logic [IW-1:0] LAST_IDX   = IW'(FFT_POINTS - 1);

    typedef enum logic {ST_STREAM, ST_PAD} state_t;

    state_t state, state_next;

    // Holds the ready output low through reset and the first edge after release.
    logic running;

    // Only {last, real} is stored; the imaginary half is always zero.
    logic [SAMPLE_WIDTH:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [AW:0]           level;
    logic [IW-1:0]         idx, idx_post;

    logic full, pop, accept, sample_wr, pad_wr, wr, wr_last, drop;

    assign full   = (level == FULL_LEVEL);
    assign pop    = m_axis_tvalid && m_axis_tready;

    assign sample_ready_out = running && (state == ST_STREAM) && ((ALLOW_DROP != 0) || !full);
    assign accept    = sample_valid_in && sample_ready_out;
    // In drop mode a sample meeting a full FIFO still lands if the head leaves this cycle.
    assign sample_wr = accept && (!full || pop);
    assign drop      = accept && !sample_wr;
    assign pad_wr    = running && (state == ST_PAD) && !full;
    assign wr        = sample_wr || pad_wr;
    assign wr_last   = (idx == LAST_IDX);
    // Frame index after this cycle's write; a flush decision looks at this value.
    assign idx_post  = wr ? (wr_last ? '0 : idx + 1'b1) : idx;

    always_comb begin
        state_next = state;
        case (state)
            ST_STREAM: if (running && flush_in && (idx_post != '0)) state_next = ST_PAD;
            ST_PAD:    if (pad_wr && wr_last) state_next = ST_STREAM;
            default:   state_next = ST_STREAM;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state           <= ST_STREAM;
            running         <= 1'b0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            level           <= '0;
            idx             <= '0;
            frame_count_out <= '0;
            overflow_out    <= 1'b0;
        end else begin
            state   <= state_next;
            running <= 1'b1;
            idx     <= idx_post;
            if (wr)  wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({wr, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (pop && m_axis_tlast) frame_count_out <= frame_count_out + 1'b1;
            if (drop) overflow_out <= 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (wr) mem[wr_ptr] <= {wr_last, sample_wr ? sample_in : {SAMPLE_WIDTH{1'b0}}};
    end

    // Storage is not reset, so the head is masked whenever the FIFO is empty.
    assign m_axis_tvalid  = (level != '0);
    assign m_axis_tdata   = m_axis_tvalid ? {{SAMPLE_WIDTH{1'b0}}, mem[rd_ptr][SAMPLE_WIDTH-1:0]} : '0;
    assign m_axis_tlast   = m_axis_tvalid && mem[rd_ptr][SAMPLE_WIDTH];
    assign fifo_level_out = level;

endmodule
